// File: rtl/cim_macro_ctrl.sv
// cim_macro_ctrl: sequences weight load, readback and compute cycles onto a CIM macro's
// raw STDW/STDR/CIM_en pins from valid/ready streams. Rev 1.0
`default_nettype none

module cim_macro_ctrl #(
    parameter int ROWS = 64,
    parameter int AW   = 6,
    parameter int WW   = 32,
    parameter int ACTW = 256,
    parameter int PSW  = 112
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start_i,
    input  logic            rb_start_i,
    input  logic            w_valid_i,
    output logic            w_ready_o,
    input  logic [WW-1:0]   w_data_i,
    output logic            rb_valid_o,
    input  logic            rb_ready_i,
    output logic [WW-1:0]   rb_data_o,
    input  logic            act_valid_i,
    output logic            act_ready_o,
    input  logic [ACTW-1:0] act_data_i,
    output logic            ps_valid_o,
    input  logic            ps_ready_i,
    output logic [PSW-1:0]  ps_data_o,
    output logic            busy_o,
    output logic            CIM_en_o,
    output logic            STDW_o,
    output logic            STDR_o,
    output logic [AW-1:0]   STD_A_o,
    output logic [WW-1:0]   weight_in_o,
    output logic [ACTW-1:0] act_in_o,
    input  logic [WW-1:0]   weight_out_i,
    input  logic [PSW-1:0]  PSUM_i
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_HOLD  = 3'd3,
        S_COMP     = 3'd4,
        S_OUT      = 3'd5
    } state_e;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [AW-1:0]   std_a_q, std_a_d;
    logic [WW-1:0]   weight_in_q, weight_in_d;
    logic            stdw_q, stdw_d;
    logic [ACTW-1:0] act_in_q, act_in_d;
    logic [WW-1:0]   rb_data_q, rb_data_d;
    logic [PSW-1:0]  ps_data_q, ps_data_d;
    logic            rdy_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            std_a_q     <= '0;
            weight_in_q <= '0;
            stdw_q      <= 1'b0;
            act_in_q    <= '0;
            rb_data_q   <= '0;
            ps_data_q   <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            std_a_q     <= std_a_d;
            weight_in_q <= weight_in_d;
            stdw_q      <= stdw_d;
            act_in_q    <= act_in_d;
            rb_data_q   <= rb_data_d;
            ps_data_q   <= ps_data_d;
            rdy_en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        std_a_d     = std_a_q;
        weight_in_d = weight_in_q;
        stdw_d      = 1'b0;
        act_in_d    = act_in_q;
        rb_data_d   = rb_data_q;
        ps_data_d   = ps_data_q;
        w_ready_o   = 1'b0;
        rb_valid_o  = 1'b0;
        act_ready_o = 1'b0;
        ps_valid_o  = 1'b0;
        STDR_o      = 1'b0;
        CIM_en_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rdy_en_q holds act_ready low for the first cycle out of reset
                act_ready_o = rdy_en_q && !load_start_i && !rb_start_i;
                if (load_start_i) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                end else if (rb_start_i) begin
                    state_d = S_RD_ISSUE;
                    row_d   = '0;
                    std_a_d = '0;
                end else if (act_valid_i && act_ready_o) begin
                    act_in_d = act_data_i;
                    state_d  = S_COMP;
                end
            end
            S_LOAD: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    std_a_d     = row_q;
                    weight_in_d = w_data_i;
                    stdw_d      = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end
            end
            S_RD_ISSUE: begin
                STDR_o    = 1'b1;
                rb_data_d = weight_out_i;
                state_d   = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                rb_valid_o = 1'b1;
                if (rb_ready_i) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + AW'(1);
                        std_a_d = row_q + AW'(1);
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_COMP: begin
                CIM_en_o  = 1'b1;
                ps_data_d = PSUM_i;
                state_d   = S_OUT;
            end
            S_OUT: begin
                ps_valid_o = 1'b1;
                if (ps_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign STDW_o      = stdw_q;
    assign STD_A_o     = std_a_q;
    assign weight_in_o = weight_in_q;
    assign act_in_o    = act_in_q;
    assign rb_data_o   = rb_data_q;
    assign ps_data_o   = ps_data_q;

endmodule

`default_nettype wire

// File: tb/tb_cim_macro_ctrl.sv
// tb_cim_macro_ctrl: scoreboard bench for cim_macro_ctrl with a behavioural macro attached.
// Rev 1.0
`default_nettype none

module tb_cim_macro_ctrl;
    localparam int ROWS = 64, AW = 6, WW = 32, ACTW = 256, PSW = 112;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic load_start, rb_start, w_valid, w_ready, rb_valid, rb_ready;
    logic act_valid, act_ready, ps_valid, ps_ready, busy, cim_en, stdw, stdr;
    logic [WW-1:0]   w_data, rb_data, weight_in, weight_out;
    logic [ACTW-1:0] act_data, act_in;
    logic [PSW-1:0]  ps_data, psum;
    logic [AW-1:0]   std_a;

    cim_macro_ctrl #(.ROWS(ROWS), .AW(AW), .WW(WW), .ACTW(ACTW), .PSW(PSW)) dut (
        .clk(clk), .rst(rst),
        .load_start_i(load_start), .rb_start_i(rb_start),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .rb_valid_o(rb_valid), .rb_ready_i(rb_ready), .rb_data_o(rb_data),
        .act_valid_i(act_valid), .act_ready_o(act_ready), .act_data_i(act_data),
        .ps_valid_o(ps_valid), .ps_ready_i(ps_ready), .ps_data_o(ps_data),
        .busy_o(busy), .CIM_en_o(cim_en), .STDW_o(stdw), .STDR_o(stdr),
        .STD_A_o(std_a), .weight_in_o(weight_in), .act_in_o(act_in),
        .weight_out_i(weight_out), .PSUM_i(psum)
    );

    // Behavioural macro: row memory written on STDW, read and MAC'd combinationally
    logic [WW-1:0] mmem    [ROWS];
    logic [WW-1:0] ref_mem [ROWS];
    logic [WW-1:0] wgen    [ROWS];

    always @(posedge clk) if (stdw) mmem[std_a] <= weight_in;

    function automatic logic [PSW-1:0] macro_mac(input logic [ACTW-1:0] a);
        logic [PSW-1:0] res = '0;
        for (int c = 0; c < 8; c++) begin
            int s = 0;
            for (int r = 0; r < ROWS; r++) s += int'(a[4*r +: 4]) * int'(mmem[r][4*c +: 4]);
            res[14*c +: 14] = 14'(s);
        end
        return res;
    endfunction

    assign weight_out = stdr ? mmem[std_a] : '0;
    assign psum       = cim_en ? macro_mac(act_in) : '0;

    // Reference: dot product of the activation vector with the intended weights
    function automatic logic [PSW-1:0] psum_ref(input logic [ACTW-1:0] a);
        logic [PSW-1:0] res = '0;
        for (int c = 0; c < 8; c++) begin
            int s = 0;
            for (int r = 0; r < ROWS; r++) s += int'(a[4*r +: 4]) * int'(ref_mem[r][4*c +: 4]);
            res[14*c +: 14] = 14'(s);
        end
        return res;
    endfunction

    int errors = 0, checks = 0;
    int onehot_bad = 0, busy_ready_bad = 0;
    bit mon_en = 1'b0;

    logic [AW+WW-1:0] wr_q [$];
    logic [AW-1:0]    rd_q [$];
    logic [WW-1:0]    rb_q [$];
    logic [PSW-1:0]   ps_q [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [AW+WW-1:0] e;
            if (int'(stdw) + int'(stdr) + int'(cim_en) > 1) onehot_bad++;
            if (busy && act_ready) busy_ready_bad++;
            if (stdw) begin
                if (wr_q.size() == 0) chk("stdw_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("stdw_addr", std_a, e[AW+WW-1:WW]);
                    chk("stdw_data", weight_in, e[WW-1:0]);
                end
            end
            if (stdr) begin
                if (rd_q.size() == 0) chk("stdr_unexpected", 1, 0);
                else chk("stdr_addr", std_a, rd_q.pop_front());
            end
            if (rb_valid && rb_ready) begin
                if (rb_q.size() == 0) chk("rb_unexpected", 1, 0);
                else chk("rb_data", rb_data, rb_q.pop_front());
            end
            if (ps_valid && ps_ready) begin
                if (ps_q.size() == 0) chk("ps_unexpected", 1, 0);
                else chk("ps_data", ps_data, ps_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(!busy && act_ready) && cyc < 300);
        chk("idle_reached", busy, 0);
    endtask

    // mode 0: continuous w_valid, 1: every other cycle, 2: random
    task automatic do_load(input int mode, input bit hold_act, output int cyc);
        int idx = 0;
        bit hs;
        wait_idle();
        for (int r = 0; r < ROWS; r++) begin
            wr_q.push_back({AW'(r), wgen[r]});
            ref_mem[r] = wgen[r];
        end
        @(posedge clk); #1;
        load_start = 1'b1;
        act_valid  = hold_act;
        if (hold_act) begin
            @(negedge clk);
            chk("act_ready_prio", act_ready, 0);
        end
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("busy_rise", busy, 1);
        cyc = 0;
        while (idx < ROWS && cyc < 2000) begin
            w_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            w_data  = w_valid ? wgen[idx] : $urandom;
            @(negedge clk);
            hs = w_valid && w_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        w_valid   = 1'b0;
        act_valid = 1'b0;
        chk("load_rows", idx, ROWS);
    endtask

    task automatic do_rb();
        int cyc = 0;
        wait_idle();
        for (int r = 0; r < ROWS; r++) begin
            rd_q.push_back(AW'(r));
            rb_q.push_back(ref_mem[r]);
        end
        @(posedge clk); #1 rb_start = 1'b1;
        @(posedge clk); #1 rb_start = 1'b0;
        while (rb_q.size() > 0 && cyc < 2000) begin
            rb_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        rb_ready = 1'b0;
        chk("rb_all_beats", rb_q.size(), 0);
        chk("stdr_all_rows", rd_q.size(), 0);
    endtask

    // stall=0 holds ps_ready high and checks the back-to-back timing
    task automatic do_comp(input bit stall, input logic [ACTW-1:0] a);
        int cyc = 0;
        wait_idle();
        @(posedge clk); #1;
        act_valid = 1'b1;
        act_data  = a;
        ps_ready  = !stall;
        @(negedge clk);
        chk("act_ready_idle", act_ready, 1);
        ps_q.push_back(psum_ref(a));
        @(posedge clk); #1;
        act_valid = 1'b0;
        act_data  = {8{$urandom}};
        chk("cim_en_t1", cim_en, 1);
        chk("act_in_t1", act_in, a);
        @(posedge clk); #1;
        chk("cim_en_t2", cim_en, 0);
        chk("ps_valid_t2", ps_valid, 1);
        if (!stall) begin
            @(posedge clk); #1;
            chk("act_ready_t3", act_ready, 1);
        end else begin
            while (busy && cyc < 200) begin
                ps_ready = 1'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
        end
        ps_ready = 1'b0;
        chk("ps_drained", ps_q.size(), 0);
    endtask

    initial begin
        int cyc, idx;
        bit hs;
        logic [ACTW-1:0] a;
        load_start = 0; rb_start = 0; w_valid = 0; w_data = 0;
        rb_ready = 0; act_valid = 0; act_data = 0; ps_ready = 0;
        for (int r = 0; r < ROWS; r++) begin
            mmem[r] = '0;
            ref_mem[r] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stdw", stdw, 0);        chk("rst_stdr", stdr, 0);
        chk("rst_cim_en", cim_en, 0);    chk("rst_std_a", std_a, 0);
        chk("rst_weight_in", weight_in, 0); chk("rst_act_in", act_in, 0);
        chk("rst_rb_data", rb_data, 0);  chk("rst_ps_data", ps_data, 0);
        chk("rst_w_ready", w_ready, 0);  chk("rst_rb_valid", rb_valid, 0);
        chk("rst_act_ready", act_ready, 0); chk("rst_ps_valid", ps_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("act_ready_after_rst", act_ready, 1);

        // continuous load of the {8{row[3:0]}} pattern
        for (int r = 0; r < ROWS; r++) wgen[r] = {8{4'(r)}};
        do_load(0, 0, cyc);
        chk("load_cycles", cyc, ROWS);
        chk("busy_fall", busy, 0);
        chk("stdw_trailing", stdw, 1);
        do_rb();

        // gapped load of random rows, then readback with stalls
        for (int r = 0; r < ROWS; r++) wgen[r] = $urandom;
        do_load(1, 0, cyc);
        chk("gapped_load_cycles", cyc, 2 * ROWS - 1);
        do_rb();

        // all-ones weights and activations; each lane sums to 64
        for (int r = 0; r < ROWS; r++) wgen[r] = 32'h1111_1111;
        do_load(2, 0, cyc);
        wait_idle();
        a = {64{4'h1}};
        @(posedge clk); #1;
        act_valid = 1'b1;
        act_data  = a;
        ps_ready  = 1'b0;
        ps_q.push_back(psum_ref(a));
        @(posedge clk); #1;
        act_valid = 1'b0;
        chk("ones_cim_en_t1", cim_en, 1);
        @(posedge clk); #1;
        chk("ones_ps_valid_t2", ps_valid, 1);
        chk("ones_lane64", ps_data, {8{14'd64}});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ps_hold_data", ps_data, ps_q[0]);
            chk("ps_hold_valid", ps_valid, 1);
            @(posedge clk); #1;
        end
        ps_ready = 1'b1;
        @(posedge clk); #1;
        ps_ready = 1'b0;
        chk("ones_busy_after", busy, 0);

        // load_start wins over act_valid; act_valid kept high throughout the load
        for (int r = 0; r < ROWS; r++) wgen[r] = $urandom;
        do_load(2, 1, cyc);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) a[32*k +: 32] = $urandom;
            do_comp(n[0], a);
        end

        // reset partway through a load: rows 0..19 written, row 20 dropped
        wait_idle();
        for (int r = 0; r < ROWS; r++) wgen[r] = $urandom;
        for (int r = 0; r < 20; r++) wr_q.push_back({AW'(r), wgen[r]});
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 20 && cyc < 200) begin
            w_valid = 1'b1;
            w_data  = wgen[idx];
            @(negedge clk);
            hs = w_valid && w_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        rst     = 1'b1;
        w_valid = 1'b1;
        w_data  = wgen[20];
        @(posedge clk); #1;
        chk("mid_rst_stdw", stdw, 0);      chk("mid_rst_busy", busy, 0);
        chk("mid_rst_w_ready", w_ready, 0); chk("mid_rst_std_a", std_a, 0);
        chk("mid_rst_weight_in", weight_in, 0); chk("mid_rst_act_ready", act_ready, 0);
        chk("mid_rst_act_in", act_in, 0);  chk("mid_rst_ps_data", ps_data, 0);
        rst     = 1'b0;
        w_valid = 1'b0;
        chk("mid_rst_writes", wr_q.size(), 0);
        do_load(0, 0, cyc);
        do_rb();
        for (int k = 0; k < 8; k++) a[32*k +: 32] = $urandom;
        do_comp(0, a);

        repeat (4) @(posedge clk);
        chk("onehot_strobes", onehot_bad, 0);
        chk("act_ready_while_busy", busy_ready_bad, 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("rb_q_empty", rb_q.size(), 0);
        chk("ps_q_empty", ps_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cim_macro_ctrl.md
# cim_macro_ctrl

Sequencing controller that drives an 8-column, 64-row CIM macro from the system side. It streams 64 weight rows into the macro through standard-write cycles. It reads rows back through standard-read cycles. It issues compute operations: one 256-bit activation vector in, one 112-bit PSUM vector out. It sits between the layer scheduler (valid/ready streams) and the macro's raw STDW/STDR/CIM_en pins, and guarantees the macro's mode strobes are one-hot single-cycle pulses with stable address and data.

## Interface
- ROWS, 64, macro rows (weights loaded/read rows 0..ROWS-1)
- AW, 6, row address width
- WW, 32, weight row width (4b x 8 columns)
- ACTW, 256, activation width (4b x 64)
- PSW, 112, PSUM width (14b x 8)

- clk  in  1  clock; everything samples on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  begin 64-row weight load (honoured in IDLE only)
- rb_start  in  1  begin 64-row readback (honoured in IDLE only)
- w_valid / w_ready  in / out  1 / 1  weight stream handshake
- w_data  in  WW  weight row, rows delivered in order 0..63
- rb_valid / rb_ready  out / in  1 / 1  readback stream handshake
- rb_data  out  WW  read-back row
- act_valid / act_ready  in / out  1 / 1  activation handshake
- act_data  in  ACTW  activation vector
- ps_valid / ps_ready  out / in  1 / 1  result handshake
- ps_data  out  PSW  captured PSUM
- busy  out  1  high in any state except IDLE
- CIM_en, STDW, STDR  out  1 each  macro mode strobes
- STD_A  out  AW  macro row address
- weight_in  out  WW  macro write data
- act_in  out  ACTW  macro activations
- weight_out  in  WW  macro read data (combinational from STDR/STD_A)
- PSUM  in  PSW  macro result (combinational from act_in while CIM_en)

## Operation
- States: IDLE, LOAD, RD_ISSUE, RD_HOLD, COMP, OUT.
- IDLE priority: load_start > rb_start > act_valid. act_ready = 1 only in IDLE with load_start = rb_start = 0.
- LOAD:
  - w_ready = 1.
  - Each w_valid&w_ready registers STD_A = row, weight_in = w_data and STDW = 1 for the next cycle only. row increments.
  - After the row-63 handshake: go to IDLE. The final STDW pulse is emitted in the first IDLE cycle.
  - Gaps in w_valid produce gaps in STDW. Nothing else changes.
- RD_ISSUE:
  - STDR = 1 with STD_A = row for one cycle. weight_out is registered into rb_data at the end of that cycle.
  - Then RD_HOLD: rb_valid = 1 until rb_ready.
  - On the handshake: row+1, back to RD_ISSUE. After row 63: IDLE.
- COMP:
  - On entry, act_in holds the registered act_data.
  - CIM_en = 1 for exactly one cycle. PSUM is registered into ps_data at the end of that cycle.
  - Then OUT: ps_valid = 1 until ps_ready, then IDLE.
- act_in retains its last value outside COMP. weight_in and STD_A retain their last value. PSUM is not interpreted; all 112 bits pass through unchanged.
- Invariant: at most one of STDW, STDR, CIM_en is high in any cycle.
- load_start, rb_start and act_valid are ignored while busy. There is no queuing.
- Row counter is AW bits. The terminal test is row == ROWS-1, which prevents wrap into row 0.

## Timing
- Reset values: all strobes 0; STD_A, weight_in, act_in, rb_data, ps_data = 0; w_ready, rb_valid, act_ready, ps_valid, busy = 0; state IDLE; row = 0.
  - act_ready becomes 1 the cycle after rst deasserts.
- rst during any state: next cycle is IDLE with reset values. The partial load is abandoned and STDW does not fire for an in-flight row.
- Load throughput: 1 row/cycle. Minimum load is 64 handshake cycles plus 1 trailing STDW cycle.
- Readback: 2 cycles per row minimum (RD_ISSUE + RD_HOLD with rb_ready = 1).
- Compute latency: act handshake at cycle t; CIM_en high at t+1; ps_valid high from t+2.
  - Back-to-back: next act_ready is at t+3 when ps_ready = 1 at t+2.
- busy rises the cycle after the accepting handshake or start. It falls in the cycle the FSM returns to IDLE.

## Test plan
- Load rows w_data = {8{row[3:0]}} for row 0..63 with continuous w_valid -> 64 STDW pulses, STD_A = 0..63 in order, weight_in matches, busy low after cycle 65.
- Load with w_valid toggled every other cycle -> STDW only on cycles after handshakes, addresses still 0..63, no duplicates.
- Load pattern, then rb_start with rb_ready randomly stalled (behavioural macro model) -> 64 rb_data beats equal to loaded rows; STDR pulse one cycle per row.
- act_data = all 4'h1, weights all 4'h1 -> CIM_en one cycle at t+1; ps_valid at t+2 with each 14b lane = 64; ps_data held while ps_ready = 0 for 5 cycles.
- load_start and act_valid asserted together in IDLE -> LOAD chosen, act_ready = 0; act_valid ignored while busy.
- rst asserted at row 20 of a load -> next cycle all outputs at reset values, no STDW; a new load restarts at STD_A = 0.
